// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DefaultN = 4;

    // Iteration counter width; never below one bit so N=1 still elaborates.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefaultCntW = cnt_width(DefaultN);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StErr
    } div_state_e;

endpackage

// File: rtl/div_datapath.sv
// Partial-remainder (A) and quotient (Q) registers with the restoring subtract step.
module div_datapath
    import div_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic           clk_i,
    input  logic           clr_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [2*N-1:0] dvd_i,
    input  logic [N-1:0]   dvs_i,
    output logic [N-1:0]   quo_next_o,
    output logic [N-1:0]   rem_next_o
);

    logic [N:0]   a_q, a_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] dvs_q, dvs_d;

    logic [N+1:0] ext;
    logic [N+1:0] diff;
    logic         borrow;
    logic [N:0]   a_step;
    logic [N-1:0] q_step;

    // A stays below the divisor, so {A,Q} shifted left fits in N+1 bits and
    // the extra top bit of the subtraction acts as the borrow.
    always_comb begin
        ext    = {a_q, q_q[N-1]};
        diff   = ext - {2'b00, dvs_q};
        borrow = diff[N+1];
        a_step = borrow ? ext[N:0] : diff[N:0];
        q_step = {q_q[N-2:0], ~borrow};
    end

    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        dvs_d = dvs_q;
        if (load_i) begin
            a_d   = {1'b0, dvd_i[2*N-1:N]};
            q_d   = dvd_i[N-1:0];
            dvs_d = dvs_i;
        end else if (step_i) begin
            a_d = a_step;
            q_d = q_step;
        end
    end

    assign quo_next_o = q_step;
    assign rem_next_o = a_step[N-1:0];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            a_q   <= '0;
            q_q   <= '0;
            dvs_q <= '0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor in N iteration cycles.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [2*N-1:0] dvd,
    input  logic [N-1:0]   dvs,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           dz,
    output logic           ovf
);

    localparam int unsigned CntW = cnt_width(N);

    div_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;

    logic          accept;
    logic          pre_err;
    logic          last_iter;
    logic          load;
    logic          step;
    logic [N-1:0]  quo_next;
    logic [N-1:0]  rem_next;

    div_datapath #(
        .N (N)
    ) u_datapath (
        .clk_i      (clk),
        .clr_i      (clr),
        .load_i     (load),
        .step_i     (step),
        .dvd_i      (dvd),
        .dvs_i      (dvs),
        .quo_next_o (quo_next),
        .rem_next_o (rem_next)
    );

    // A high half >= divisor means the quotient cannot fit in N bits.
    assign accept    = (state_q == StIdle) && start;
    assign pre_err   = (dvs == '0) || (dvd[2*N-1:N] >= dvs);
    assign last_iter = (cnt_q == CntW'(N - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = pre_err ? StErr : StRun;
            end
            StRun: begin
                if (last_iter) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dz_d  = dz_q;
        ovf_d = ovf_q;
        if (accept) begin
            cnt_d = '0;
            dz_d  = 1'b0;
            ovf_d = 1'b0;
            if (pre_err) begin
                quo_d = '0;
                rem_d = '0;
                dz_d  = (dvs == '0);
                ovf_d = (dvs != '0);
            end
        end else if (state_q == StRun) begin
            cnt_d = cnt_q + CntW'(1);
            if (last_iter) begin
                quo_d = quo_next;
                rem_d = rem_next;
            end
        end
    end

    always_comb begin
        load = accept;
        step = (state_q == StRun);
        busy = (state_q == StRun) || (state_q == StErr);
        done = (state_q == StDone) || (state_q == StErr);
    end

    assign q   = quo_q;
    assign r   = rem_q;
    assign dz  = dz_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and sweep checks for seq_divider with N=4.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic       busy;
    logic       done;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_divider #(
        .N (4)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .dvd   (dvd),
        .dvs   (dvs),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dz    (dz),
        .ovf   (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one division and stops in the cycle where done is high.
    // lat counts cycles after the accepting edge; 99 means done never came.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                           output int lat, output int busy_n, output logic c1_dz);
        if (done) tick();
        dvd   = a;
        dvs   = b;
        start = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 1;
        busy_n = 0;
        c1_dz  = dz;
        while (!done && lat < 20) begin
            if (busy) busy_n++;
            tick();
            lat++;
        end
        if (!done) lat = 99;
    endtask

    task automatic test_reset();
        clr   = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        tick();
        tick();
        clr = 1'b0;
        total++;
        if ({busy, done, dz, ovf} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got busy/done/dz/ovf=%b want 0000", {busy, done, dz, ovf});
        end
        total++;
        if ({q, r} !== 8'h00) begin
            bad++;
            $display("FAIL reset_qr: got q=%h r=%h want 0 0", q, r);
        end
    endtask

    task automatic test_basic();
        int   lat, bn;
        logic c1;
        run_div(8'h3F, 4'h7, lat, bn, c1);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL basic_latency: got %0d want 5", lat); end
        total++;
        if (q !== 4'h9 || r !== 4'h0) begin
            bad++; $display("FAIL basic_result: got q=%h r=%h want 9 0", q, r);
        end
        total++;
        if (dz !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL basic_flags: got dz=%b ovf=%b want 0 0", dz, ovf);
        end
        total++;
        if (bn !== 4 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_busy: got run_busy=%0d busy_at_done=%b want 4 0", bn, busy);
        end
        tick();
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL basic_pulse: got done=%b want 0", done); end
        tick();
        tick();
        total++;
        if (q !== 4'h9 || r !== 4'h0) begin
            bad++; $display("FAIL basic_hold: got q=%h r=%h want 9 0", q, r);
        end
    endtask

    task automatic test_back_to_back();
        int   lat, bn;
        logic c1;
        run_div(8'h64, 4'h7, lat, bn, c1);
        total++;
        if (lat !== 5 || q !== 4'hE || r !== 4'h2) begin
            bad++; $display("FAIL b2b_first: got lat=%0d q=%h r=%h want 5 e 2", lat, q, r);
        end
        run_div(8'h00, 4'h5, lat, bn, c1);
        total++;
        if (lat !== 5 || q !== 4'h0 || r !== 4'h0) begin
            bad++; $display("FAIL b2b_zero: got lat=%0d q=%h r=%h want 5 0 0", lat, q, r);
        end
    endtask

    task automatic test_errors();
        int   lat, bn;
        logic c1;
        run_div(8'h70, 4'h7, lat, bn, c1);
        total++;
        if (lat !== 1 || ovf !== 1'b1 || dz !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL err_ovf: got lat=%0d ovf=%b dz=%b busy=%b want 1 1 0 1", lat, ovf, dz, busy);
        end
        total++;
        if (q !== 4'h0 || r !== 4'h0) begin
            bad++; $display("FAIL err_ovf_qr: got q=%h r=%h want 0 0", q, r);
        end
        run_div(8'h12, 4'h0, lat, bn, c1);
        total++;
        if (lat !== 1 || dz !== 1'b1 || ovf !== 1'b0) begin
            bad++; $display("FAIL err_dz: got lat=%0d dz=%b ovf=%b want 1 1 0", lat, dz, ovf);
        end
        run_div(8'h3F, 4'h7, lat, bn, c1);
        total++;
        if (c1 !== 1'b0 || q !== 4'h9 || dz !== 1'b0) begin
            bad++; $display("FAIL err_clear: got dz_after_accept=%b q=%h dz=%b want 0 9 0", c1, q, dz);
        end
    endtask

    task automatic test_ignore_start();
        int         dones = 0;
        logic [3:0] fq = 4'hF;
        logic [3:0] fr = 4'hF;
        if (done) tick();
        dvd   = 8'h3F;
        dvs   = 4'h7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dvd   = 8'hFF;
        dvs   = 4'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        dvd   = 8'hAA;
        dvs   = 4'h3;
        for (int i = 0; i < 15; i++) begin
            if (done) begin
                if (dones == 0) begin fq = q; fr = r; end
                dones++;
            end
            tick();
        end
        total++;
        if (dones !== 1 || fq !== 4'h9 || fr !== 4'h0) begin
            bad++; $display("FAIL ignore_start: got dones=%0d q=%h r=%h want 1 9 0", dones, fq, fr);
        end
    endtask

    task automatic test_clr_mid();
        int   lat, bn;
        logic c1;
        if (done) tick();
        dvd   = 8'h64;
        dvs   = 4'h7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 4'h0 || r !== 4'h0) begin
            bad++;
            $display("FAIL clr_mid: got busy=%b done=%b q=%h r=%h want 0 0 0 0", busy, done, q, r);
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL clr_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        run_div(8'h31, 4'h7, lat, bn, c1);
        total++;
        if (lat !== 5 || q !== 4'h7 || r !== 4'h0) begin
            bad++; $display("FAIL clr_restart: got lat=%0d q=%h r=%h want 5 7 0", lat, q, r);
        end
    endtask

    task automatic test_sweep();
        int   lat, bn;
        logic c1;
        int   eq, er;
        for (int b = 1; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                if ((a >> 4) < b) begin
                    run_div(8'(a), 4'(b), lat, bn, c1);
                    eq = a / b;
                    er = a % b;
                    total++;
                    if (lat != 5 || int'(q) != eq || int'(r) != er || int'(q) * b + int'(r) != a
                        || int'(r) >= b || dz !== 1'b0 || ovf !== 1'b0) begin
                        bad++;
                        $display("FAIL sweep %0d/%0d: got lat=%0d q=%0d r=%0d want 5 %0d %0d",
                                 a, b, lat, q, r, eq, er);
                    end
                end
            end
        end
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_errors();
        test_ignore_start();
        test_clr_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
